// File: rtl/data_sync_ctrl_pkg.sv
// data_sync_pkg: shared types and defaults for the data_sync_ctrl CDC slice.
//   state_t            : handshake FSM state, 1-bit encoding
//   DEFAULT_BUS_WIDTH  : default transferred word width
//   DEFAULT_NUM_STAGES : default BUS_ENABLE synchronizer depth
package data_sync_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_LOW = 1'b1
    } state_t;

    localparam int unsigned DEFAULT_BUS_WIDTH  = 8;
    localparam int unsigned DEFAULT_NUM_STAGES = 2;

endpackage

// File: rtl/data_sync_ctrl_bit_sync.sv
// bit_sync: single-bit multi-flop synchronizer.
//   CLK      : destination clock
//   RST      : asynchronous active-low reset, clears every stage to 0
//   async_in : asynchronous input level
//   sync_out : last stage of the chain
module bit_sync #(
    parameter int unsigned NUM_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic async_in,
    output logic sync_out
);

    logic [NUM_STAGES-1:0] chain;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            chain <= '0;
        end else begin
            chain[0] <= async_in;
            for (int unsigned i = 1; i < NUM_STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign sync_out = chain[NUM_STAGES-1];

endmodule

// File: rtl/data_sync_ctrl.sv
// data_sync_ctrl: destination-side controller for a multi-bit CDC transfer.
// Runs a four-phase REQ/ACK handshake against an asynchronous source; only
// BUS_ENABLE is synchronized, UNSYNC_BUS is captured under the handshake.
//   CLK          : destination clock
//   RST          : asynchronous active-low reset
//   UNSYNC_BUS   : source data, stable while the request is outstanding
//   BUS_ENABLE   : asynchronous request level
//   SYNC_READY   : consumer accepts SYNC_BUS this cycle
//   SYNC_BUS     : captured data word
//   SYNC_VALID   : SYNC_BUS holds an unconsumed word
//   ENABLE_PULSE : one-cycle strobe on each capture
//   ACK          : handshake acknowledge level
//   PROTO_ERR    : sticky, request withdrawn while stalled
module data_sync_ctrl
    import data_sync_pkg::*;
#(
    parameter int unsigned BUS_WIDTH  = DEFAULT_BUS_WIDTH,
    parameter int unsigned NUM_STAGES = DEFAULT_NUM_STAGES
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
    input  logic                 BUS_ENABLE,
    input  logic                 SYNC_READY,
    output logic [BUS_WIDTH-1:0] SYNC_BUS,
    output logic                 SYNC_VALID,
    output logic                 ENABLE_PULSE,
    output logic                 ACK,
    output logic                 PROTO_ERR
);

    state_t state;
    state_t state_next;
    logic   en_sync;
    logic   en_prev;
    logic   slot_free;
    logic   capture;

    bit_sync #(
        .NUM_STAGES(NUM_STAGES)
    ) u_en_sync (
        .CLK      (CLK),
        .RST      (RST),
        .async_in (BUS_ENABLE),
        .sync_out (en_sync)
    );

    assign slot_free = !SYNC_VALID || SYNC_READY;
    assign capture   = (state == IDLE) && en_sync && slot_free;

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:     if (capture)  state_next = WAIT_LOW;
            WAIT_LOW: if (!en_sync) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // ACK decodes the 1-bit state register directly, so it stays glitch-free
    always_comb begin
        ACK = (state == WAIT_LOW);
    end

    // Datapath and status registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            SYNC_BUS     <= '0;
            SYNC_VALID   <= 1'b0;
            ENABLE_PULSE <= 1'b0;
            PROTO_ERR    <= 1'b0;
            en_prev      <= 1'b0;
        end else begin
            en_prev      <= en_sync;
            ENABLE_PULSE <= capture;
            if (capture) begin
                SYNC_BUS <= UNSYNC_BUS;
            end
            // A capture coinciding with a pop keeps VALID high: no bubble
            if (capture) begin
                SYNC_VALID <= 1'b1;
            end else if (SYNC_VALID && SYNC_READY) begin
                SYNC_VALID <= 1'b0;
            end
            // Falling en_sync seen in IDLE means the request left before capture
            if ((state == IDLE) && en_prev && !en_sync) begin
                PROTO_ERR <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_data_sync_ctrl.sv
module tb_data_sync_ctrl;

    logic       CLK;
    logic       RST;
    logic [7:0] UNSYNC_BUS;
    logic       BUS_ENABLE;
    logic       SYNC_READY;
    logic [7:0] SYNC_BUS;
    logic       SYNC_VALID;
    logic       ENABLE_PULSE;
    logic       ACK;
    logic       PROTO_ERR;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;

    data_sync_ctrl #(
        .BUS_WIDTH  (8),
        .NUM_STAGES (2)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .UNSYNC_BUS   (UNSYNC_BUS),
        .BUS_ENABLE   (BUS_ENABLE),
        .SYNC_READY   (SYNC_READY),
        .SYNC_BUS     (SYNC_BUS),
        .SYNC_VALID   (SYNC_VALID),
        .ENABLE_PULSE (ENABLE_PULSE),
        .ACK          (ACK),
        .PROTO_ERR    (PROTO_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (ENABLE_PULSE === 1'b1) pulse_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wait_ack_low(input string tag);
        int budget;
        budget = 0;
        while (ACK !== 1'b0 && budget < 10) begin
            tick(1);
            budget++;
        end
        check(tag, {31'd0, ACK}, 32'd0);
    endtask

    task automatic wait_pulse(input string tag, output logic [7:0] data);
        int budget;
        budget = 0;
        while (ENABLE_PULSE !== 1'b1 && budget < 10) begin
            tick(1);
            budget++;
        end
        check(tag, {31'd0, ENABLE_PULSE}, 32'd1);
        data = SYNC_BUS;
    endtask

    initial begin
        int p0;
        logic [7:0] got;

        RST = 1'b0;
        UNSYNC_BUS = 8'h00;
        BUS_ENABLE = 1'b0;
        SYNC_READY = 1'b0;
        tick(2);
        check("rst_bus",   {24'd0, SYNC_BUS}, 32'h00);
        check("rst_valid", {31'd0, SYNC_VALID}, 32'd0);
        check("rst_ack",   {31'd0, ACK}, 32'd0);
        check("rst_perr",  {31'd0, PROTO_ERR}, 32'd0);
        RST = 1'b1;
        tick(2);

        // Basic transfer: two-edge request latency, pop, two-edge release
        SYNC_READY = 1'b1;
        UNSYNC_BUS = 8'hA5;
        BUS_ENABLE = 1'b1;
        tick(1);
        check("basic_k_valid", {31'd0, SYNC_VALID}, 32'd0);
        tick(1);
        check("basic_k1_ack", {31'd0, ACK}, 32'd0);
        tick(1);
        check("basic_bus",   {24'd0, SYNC_BUS}, 32'hA5);
        check("basic_valid", {31'd0, SYNC_VALID}, 32'd1);
        check("basic_pulse", {31'd0, ENABLE_PULSE}, 32'd1);
        check("basic_ack",   {31'd0, ACK}, 32'd1);
        tick(1);
        check("basic_pop_valid", {31'd0, SYNC_VALID}, 32'd0);
        check("basic_pulse_off", {31'd0, ENABLE_PULSE}, 32'd0);
        check("basic_bus_hold",  {24'd0, SYNC_BUS}, 32'hA5);
        BUS_ENABLE = 1'b0;
        tick(1);
        check("basic_rel_m", {31'd0, ACK}, 32'd1);
        tick(1);
        check("basic_rel_m1", {31'd0, ACK}, 32'd1);
        tick(1);
        check("basic_rel_m2", {31'd0, ACK}, 32'd0);
        tick(2);

        // Backpressure: 8'h11 pending, 8'h22 stalls, then capture on single pop
        SYNC_READY = 1'b0;
        UNSYNC_BUS = 8'h11;
        BUS_ENABLE = 1'b1;
        tick(3);
        check("bp_first_bus", {24'd0, SYNC_BUS}, 32'h11);
        check("bp_first_ack", {31'd0, ACK}, 32'd1);
        BUS_ENABLE = 1'b0;
        tick(3);
        check("bp_first_rel", {31'd0, ACK}, 32'd0);
        UNSYNC_BUS = 8'h22;
        BUS_ENABLE = 1'b1;
        tick(4);
        check("bp_stall_ack",   {31'd0, ACK}, 32'd0);
        check("bp_stall_bus",   {24'd0, SYNC_BUS}, 32'h11);
        check("bp_stall_valid", {31'd0, SYNC_VALID}, 32'd1);
        SYNC_READY = 1'b1;
        tick(1);
        SYNC_READY = 1'b0;
        check("bp_swap_bus",   {24'd0, SYNC_BUS}, 32'h22);
        check("bp_swap_valid", {31'd0, SYNC_VALID}, 32'd1);
        check("bp_swap_pulse", {31'd0, ENABLE_PULSE}, 32'd1);
        check("bp_swap_ack",   {31'd0, ACK}, 32'd1);
        tick(1);
        check("bp_hold_valid", {31'd0, SYNC_VALID}, 32'd1);
        BUS_ENABLE = 1'b0;
        SYNC_READY = 1'b1;
        wait_ack_low("bp_rel");
        check("bp_drain", {31'd0, SYNC_VALID}, 32'd0);
        tick(2);

        // Back-to-back: four handshakes 01..04
        p0 = pulse_cnt;
        for (int i = 1; i <= 4; i++) begin
            UNSYNC_BUS = 8'(i);
            BUS_ENABLE = 1'b1;
            wait_pulse("b2b_pulse", got);
            check("b2b_data", {24'd0, got}, i);
            BUS_ENABLE = 1'b0;
            wait_ack_low("b2b_rel");
        end
        tick(2);
        check("b2b_count", pulse_cnt - p0, 32'd4);

        // Withdrawn request: pending 8'h33, 8'h44 dropped while stalled
        SYNC_READY = 1'b0;
        UNSYNC_BUS = 8'h33;
        BUS_ENABLE = 1'b1;
        wait_pulse("wd_first", got);
        BUS_ENABLE = 1'b0;
        wait_ack_low("wd_first_rel");
        p0 = pulse_cnt;
        UNSYNC_BUS = 8'h44;
        BUS_ENABLE = 1'b1;
        tick(4);
        check("wd_no_err_yet", {31'd0, PROTO_ERR}, 32'd0);
        BUS_ENABLE = 1'b0;
        tick(3);
        check("wd_perr",  {31'd0, PROTO_ERR}, 32'd1);
        check("wd_bus",   {24'd0, SYNC_BUS}, 32'h33);
        check("wd_ack",   {31'd0, ACK}, 32'd0);
        SYNC_READY = 1'b1;
        tick(3);
        check("wd_perr_sticky", {31'd0, PROTO_ERR}, 32'd1);
        check("wd_no_capture",  pulse_cnt - p0, 32'd0);
        check("wd_drained",     {31'd0, SYNC_VALID}, 32'd0);

        // Reset mid-handshake
        UNSYNC_BUS = 8'h55;
        BUS_ENABLE = 1'b1;
        tick(3);
        check("mr_ack_pre", {31'd0, ACK}, 32'd1);
        check("mr_pulse_pre", {31'd0, ENABLE_PULSE}, 32'd1);
        RST = 1'b0;
        #1;
        check("mr_ack",   {31'd0, ACK}, 32'd0);
        check("mr_valid", {31'd0, SYNC_VALID}, 32'd0);
        check("mr_bus",   {24'd0, SYNC_BUS}, 32'h00);
        check("mr_pulse", {31'd0, ENABLE_PULSE}, 32'd0);
        check("mr_perr",  {31'd0, PROTO_ERR}, 32'd0);
        BUS_ENABLE = 1'b0;
        tick(2);
        RST = 1'b1;
        tick(1);
        UNSYNC_BUS = 8'h66;
        BUS_ENABLE = 1'b1;
        tick(3);
        check("mr_fresh_bus",   {24'd0, SYNC_BUS}, 32'h66);
        check("mr_fresh_valid", {31'd0, SYNC_VALID}, 32'd1);
        check("mr_fresh_ack",   {31'd0, ACK}, 32'd1);
        BUS_ENABLE = 1'b0;
        wait_ack_low("mr_fresh_rel");
        tick(2);

        // Glitch: single-cycle BUS_ENABLE pulse
        p0 = pulse_cnt;
        UNSYNC_BUS = 8'h77;
        BUS_ENABLE = 1'b1;
        tick(1);
        BUS_ENABLE = 1'b0;
        tick(8);
        check("gl_at_most_one", {31'd0, (pulse_cnt - p0) <= 1}, 32'd1);
        check("gl_ack_released", {31'd0, ACK}, 32'd0);
        check("gl_no_perr", {31'd0, PROTO_ERR}, 32'd0);
        if (pulse_cnt - p0 == 1)
            check("gl_bus", {24'd0, SYNC_BUS}, 32'h77);
        else
            check("gl_bus_kept", {24'd0, SYNC_BUS}, 32'h66);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/data_sync_ctrl.md
# data_sync_ctrl

Destination-side controller for multi-bit clock-domain crossing. It runs a four-phase REQ/ACK handshake against an asynchronous source. BUS_ENABLE is synchronized through a single-bit synchronizer chain; the controller then captures the quasi-static UNSYNC_BUS into a holding register and presents it to a local consumer with valid/ready backpressure. It sits at the CLK-domain boundary of every multi-bit transfer, pairing with the per-bit synchronizers.

## Interface
Parameters:
- BUS_WIDTH, 8, width of the transferred data word
- NUM_STAGES, 2, flip-flop depth of the BUS_ENABLE synchronizer chain (≥1)

Ports:
- CLK  in  1  destination clock
- RST  in  1  asynchronous, active-low reset
- UNSYNC_BUS  in  BUS_WIDTH  source data; the source holds it stable from before BUS_ENABLE rises until it observes ACK high
- BUS_ENABLE  in  1  asynchronous request level from the source
- SYNC_READY  in  1  consumer accepts SYNC_BUS this cycle
- SYNC_BUS  out  BUS_WIDTH  captured data word
- SYNC_VALID  out  1  SYNC_BUS holds an unconsumed word
- ENABLE_PULSE  out  1  one-cycle strobe on each capture
- ACK  out  1  handshake acknowledge level; the source synchronizes it
- PROTO_ERR  out  1  sticky: a request was withdrawn before capture

## Operation
- en_sync is the last stage of the BUS_ENABLE chain. en_prev is en_sync delayed by one cycle.
- slot_free = !SYNC_VALID || SYNC_READY.
- FSM states:
  - IDLE: ACK=0. If en_sync && slot_free: capture UNSYNC_BUS into SYNC_BUS, set SYNC_VALID, pulse ENABLE_PULSE, set ACK, go to WAIT_LOW. If en_sync && !slot_free: stay in IDLE (stall, no ACK).
  - WAIT_LOW: ACK=1. When en_sync==0: clear ACK, go to IDLE.
- SYNC_VALID is cleared on SYNC_VALID && SYNC_READY, unless a capture occurs in the same cycle.
- Simultaneous pop and capture: SYNC_VALID stays 1 and SYNC_BUS takes the new word. No bubble.
- SYNC_BUS changes only on capture. It holds its value after consumption.
- PROTO_ERR is set when state==IDLE && en_prev && !en_sync, i.e. a request dropped while stalled. It is cleared only by reset.
- A new request in WAIT_LOW is impossible by protocol. en_sync must first fall, which returns the FSM to IDLE.
- Reset, asynchronous and active-low, including mid-handshake: chain=0, state=IDLE, SYNC_BUS=0, SYNC_VALID=0, ENABLE_PULSE=0, ACK=0, PROTO_ERR=0. The source observes ACK low and restarts its request.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- Request latency: BUS_ENABLE is first sampled high at edge k. en_sync is high after edge k+NUM_STAGES-1. Capture happens at edge k+NUM_STAGES. SYNC_VALID, ACK and ENABLE_PULSE are high after that edge. For NUM_STAGES=2 this is 2 edges.
- ENABLE_PULSE is high for exactly one cycle per capture.
- Release latency: BUS_ENABLE is sampled low at edge m. ACK falls after edge m+NUM_STAGES.
- Stalled request: capture happens at the first edge where slot_free is 1 while en_sync is 1.
- Minimum handshake period with no stall: 2·NUM_STAGES+2 CLK cycles, plus the source-side synchronization of ACK.

## Structure
- Shared package data_sync_pkg:
  - state enum {IDLE, WAIT_LOW}, 1-bit encoding
  - default constants for BUS_WIDTH and NUM_STAGES
- One sub-module, bit_sync: a single-bit NUM_STAGES flip-flop synchronizer with asynchronous active-low reset to 0. Instantiated once, for BUS_ENABLE.
- UNSYNC_BUS is never synchronized bit-wise. It is captured only under handshake.

## Test plan
All scenarios use BUS_WIDTH=8, NUM_STAGES=2.
- Basic transfer: SYNC_READY=1; UNSYNC_BUS=8'hA5, BUS_ENABLE↑ before edge k -> SYNC_BUS=8'hA5, SYNC_VALID=1, ENABLE_PULSE=1 and ACK=1 after edge k+2; SYNC_VALID=0 after edge k+3; BUS_ENABLE↓ -> ACK=0 two edges later.
- Backpressure: SYNC_READY=0 with 8'h11 pending; second request carries 8'h22 -> ACK stays 0 and SYNC_BUS stays 8'h11; SYNC_READY=1 for one cycle -> 8'h22 is captured in that same cycle and SYNC_VALID stays 1.
- Back-to-back: four full handshakes with 8'h01..8'h04 and SYNC_READY=1 -> four ENABLE_PULSE strobes, data in order, no loss or duplication.
- Withdrawn request: stall via SYNC_READY=0, then drop BUS_ENABLE before capture -> PROTO_ERR=1 and stays 1; no capture occurs.
- Reset mid-handshake: assert RST low while in WAIT_LOW -> ACK, SYNC_VALID, SYNC_BUS, ENABLE_PULSE and PROTO_ERR all 0 immediately; after release, a fresh request transfers normally.
- Glitch tolerance: a 1-cycle BUS_ENABLE pulse shorter than NUM_STAGES cycles -> either no capture, or exactly one capture followed by a normal release. Never two ENABLE_PULSE strobes.
